arb_rr4_sel: RTL
================

ARB_RR4_SEL -- requirements
Module: arb_rr4_sel

Interface
REQ-001 Parameter MAX_BEATS, default 4, meaning: maximum accepted transfers per grant (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  per-channel request; bit k = channel k (a=0, b=1, c=2, d=3 of the downstream 8-bit 4:1 mux).
REQ-005 ack  input  1  downstream accepts the current selected data word this cycle.
REQ-006 sel  output  2  registered select driven straight into the downstream mux sel port.
REQ-007 gnt  output  4  registered one-hot grant; all-zero when idle.
REQ-008 valid  output  1  registered; high while a channel is granted and sel is meaningful.
REQ-009 last  output  1  high when valid and the current beat is the final allowed beat (beat count = MAX_BEATS-1).

Function
REQ-010 FSM has exactly two states: IDLE (valid=0) and GRANT (valid=1).
REQ-011 Transfer is defined as valid=1 and ack=1 at a rising clock edge; ack while valid=0 SHALL be ignored.
REQ-012 Internal priority pointer ptr (2 bits) names the highest-priority channel; search order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-013 IDLE: at an edge with any req bit high, enter GRANT with winner w per REQ-012; sel=w, gnt=one-hot(w), beat count=0; latency req-to-valid = 1 cycle.
REQ-014 IDLE with req=0000: remain IDLE, outputs unchanged at idle values.
REQ-015 GRANT: sel and gnt SHALL be stable for the whole grant; each transfer increments the beat count by 1.
REQ-016 Release of granted channel g occurs at an edge where (transfer and beat count = MAX_BEATS-1) or req[g]=0.
REQ-017 req[g] falling in the same cycle as ack: the transfer counts, then release (no lost beat, no extra beat).
REQ-018 On release ptr SHALL become g+1 (mod 4), wrapping 3->0.
REQ-019 On release, re-arbitration uses the updated ptr at the same edge: if any req high, grant the new winner immediately (no idle bubble), beat count=0; else go IDLE.
REQ-020 A sole requester g that hits MAX_BEATS SHALL be re-granted next cycle (ptr search wraps to g last).
REQ-021 req changes on non-granted channels during GRANT SHALL NOT affect sel/gnt until release.
REQ-022 Beat count width 4 bits; SHALL never exceed MAX_BEATS-1; MAX_BEATS=1 makes last=1 throughout every grant.
REQ-023 gnt SHALL always be one-hot or zero, and gnt=0000 exactly when valid=0.

Reset
REQ-024 rst_n low SHALL immediately (asynchronously) force state=IDLE, sel=00, gnt=0000, valid=0, last=0, beat count=0, ptr=0.
REQ-025 Reset asserted mid-grant SHALL abort the grant; a transfer coinciding with the reset edge is not counted.
REQ-026 After rst_n rises, first grant is evaluated at the first subsequent rising edge with ptr=0.

Verification
REQ-027 Reset then req=1111 held, ack=1 continuous -> sel sequence 00x4, 01x4, 10x4, 11x4, 00..., last high on every 4th beat, no gap cycles.
REQ-028 req=0100 only, ack=1 -> valid 1 cycle after req, sel=10, gnt=0100, re-grant to 10 after each 4 beats, ptr wraps.
REQ-029 Grant on channel 1 (sel=01), ack=0, drop req[1] with req=1001 -> next cycle sel=11 (ptr=2 search: 2,3), gnt=1000.
REQ-030 req[0] and ack fall together on beat 2 of channel 0 -> exactly 2 transfers counted, then IDLE if req=0000, valid=0, gnt=0000.
REQ-031 rst_n pulsed low mid-grant on channel 3 (asynchronous, between edges) -> outputs to sel=00, gnt=0000, valid=0 without waiting for clk; next grant with req=1010 is channel 1.
REQ-032 Integration: arb_rr4_sel sel feeding mux8_4x1 with a=00000000, b=11111111, c=10101010, d=01010101 -> mux output equals the granted channel's word on every valid cycle.

Source files
------------

// File: rtl/arb_rr4_sel.sv
// arb_rr4_sel: 4-channel round-robin arbiter producing a registered select
// for a downstream 4:1 mux. A grant holds for up to MAX_BEATS accepted
// transfers or until the granted channel drops its request. On release the
// next winner is chosen at the same edge, so back-to-back grants have no idle cycle.
module arb_rr4_sel #(
    parameter int unsigned MAX_BEATS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       ack,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       valid,
    output logic       last
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BEATS - 1);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] gnt_q, gnt_d;
    logic [3:0] beat_q, beat_d;
    logic [1:0] ptr_q, ptr_d;

    logic [1:0] arb_base;
    logic       arb_found;
    logic [1:0] arb_win;
    logic       release_w;

    // First requesting channel in the order base, base+1, base+2, base+3 (mod 4)
    function automatic logic [2:0] rr_pick(input logic [1:0] base, input logic [3:0] r);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = base + 2'(i);
            if (!res[2] && r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // State register: all flops, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            beat_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            beat_q  <= beat_d;
            ptr_q   <= ptr_d;
        end
    end

    // Arbitration: on release the search starts at g+1, which is also the new ptr
    always_comb begin
        release_w = (state_q == GRANT) &&
                    ((ack && (beat_q == LAST_BEAT)) || !req[sel_q]);
        arb_base  = (state_q == GRANT) ? (sel_q + 2'd1) : ptr_q;
        {arb_found, arb_win} = rr_pick(arb_base, req);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (arb_found) state_d = GRANT;
            GRANT:   if (release_w && !arb_found) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant, select, beat counter and pointer updates
    always_comb begin
        sel_d  = sel_q;
        gnt_d  = gnt_q;
        beat_d = beat_q;
        ptr_d  = ptr_q;
        if (release_w) begin
            ptr_d = sel_q + 2'd1;
        end
        if ((state_q == IDLE && arb_found) || release_w) begin
            beat_d = '0;
            if (arb_found) begin
                sel_d = arb_win;
                gnt_d = 4'b0001 << arb_win;
            end else begin
                gnt_d = '0;
            end
        end else if (state_q == GRANT && ack) begin
            beat_d = beat_q + 4'd1;
        end
    end

    // Outputs
    always_comb begin
        sel   = sel_q;
        gnt   = gnt_q;
        valid = (state_q == GRANT);
        last  = (state_q == GRANT) && (beat_q == LAST_BEAT);
    end

endmodule
